// File: rtl/seg_octal_decoder.sv
// Decodes a pair of 7-segment digit beats (ones 0..7, tens 0..1) into a 16-bit one-hot value.
// The result is held on onehot_out/out_valid until the consumer handshakes.
module seg_octal_decoder #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  logic        seg_sel,
  input  logic        seg_valid,
  output logic        in_ready,
  output logic [15:0] onehot_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err
);

  typedef enum logic [1:0] {
    WAIT_ONES,
    WAIT_TENS,
    HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  ones_q, ones_d;
  logic [7:0]  idle_q, idle_d;
  logic [15:0] onehot_q, onehot_d;
  logic        out_valid_q, out_valid_d;
  logic        err_q, err_d;

  logic        ones_ok;
  logic [2:0]  ones_idx;
  logic        tens_ok;
  logic        tens_bit;
  logic        accept;

  always_comb begin
    ones_ok  = 1'b1;
    ones_idx = 3'd0;
    case (seg_in)
      7'b1111110: ones_idx = 3'd0;
      7'b0110000: ones_idx = 3'd1;
      7'b1101101: ones_idx = 3'd2;
      7'b1111001: ones_idx = 3'd3;
      7'b0110011: ones_idx = 3'd4;
      7'b1011011: ones_idx = 3'd5;
      7'b1011111: ones_idx = 3'd6;
      7'b1110000: ones_idx = 3'd7;
      default:    ones_ok  = 1'b0;
    endcase
  end

  always_comb begin
    tens_ok  = 1'b1;
    tens_bit = 1'b0;
    case (seg_in)
      7'b0000000: tens_bit = 1'b0;
      7'b0110000: tens_bit = 1'b1;
      default:    tens_ok  = 1'b0;
    endcase
  end

  assign in_ready = (state_q != HOLD);
  assign accept   = seg_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    ones_d      = ones_q;
    idle_d      = idle_q;
    onehot_d    = onehot_q;
    out_valid_d = out_valid_q;
    err_d       = 1'b0;
    case (state_q)
      WAIT_ONES: begin
        if (accept) begin
          if (!seg_sel && ones_ok) begin
            ones_d  = ones_idx;
            idle_d  = '0;
            state_d = WAIT_TENS;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WAIT_TENS: begin
        if (accept) begin
          idle_d = '0;
          if (seg_sel) begin
            if (tens_ok) begin
              onehot_d    = 16'h0001 << {tens_bit, ones_q};
              out_valid_d = 1'b1;
              state_d     = HOLD;
            end else begin
              err_d   = 1'b1;
              state_d = WAIT_ONES;
            end
          end else if (ones_ok) begin
            ones_d = ones_idx;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_ONES;
          end
        end else if (idle_q == 8'(TIMEOUT - 1)) begin
          // this idle cycle brings the count to TIMEOUT: abort the pair
          err_d   = 1'b1;
          idle_d  = '0;
          state_d = WAIT_ONES;
        end else begin
          idle_d = idle_q + 8'd1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          onehot_d    = '0;
          state_d     = WAIT_ONES;
        end
      end
      default: state_d = WAIT_ONES;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= WAIT_ONES;
      ones_q      <= '0;
      idle_q      <= '0;
      onehot_q    <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ones_q      <= ones_d;
      idle_q      <= idle_d;
      onehot_q    <= onehot_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign onehot_out = onehot_q;
  assign out_valid  = out_valid_q;
  assign err        = err_q;

endmodule

// File: tb/tb_seg_octal_decoder.sv
// Directed bench for seg_octal_decoder: hand-computed digit pairs, errors, timeout and reset.
module tb_seg_octal_decoder;

  logic        clk;
  logic        rst;
  logic [6:0]  seg_in;
  logic        seg_sel;
  logic        seg_valid;
  logic        in_ready;
  logic [15:0] onehot_out;
  logic        out_valid;
  logic        out_ready;
  logic        err;

  int unsigned total;
  int unsigned bad;

  seg_octal_decoder #(.TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_in    (seg_in),
    .seg_sel   (seg_sel),
    .seg_valid (seg_valid),
    .in_ready  (in_ready),
    .onehot_out(onehot_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one accepted beat; returns at 1 time unit after the accepting edge
  task automatic send(input logic sel, input logic [6:0] pat);
    seg_sel   = sel;
    seg_in    = pat;
    seg_valid = 1'b1;
    @(posedge clk);
    #1;
    seg_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    seg_in    = '0;
    seg_sel   = 1'b0;
    seg_valid = 1'b0;
    out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_onehot", 32'(onehot_out), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // ones 2, tens 1 -> value 10
    out_ready = 1'b1;
    send(1'b0, 7'b1101101);
    chk("p1_ones_err", 32'(err), 32'd0);
    chk("p1_ones_ready", 32'(in_ready), 32'd1);
    send(1'b1, 7'b0110000);
    chk("p1_valid", 32'(out_valid), 32'd1);
    chk("p1_onehot", 32'(onehot_out), 32'h0400);
    chk("p1_ready_hold", 32'(in_ready), 32'd0);
    chk("p1_err", 32'(err), 32'd0);
    idle(1);
    chk("p1_valid_drop", 32'(out_valid), 32'd0);
    chk("p1_onehot_clr", 32'(onehot_out), 32'd0);
    chk("p1_ready_back", 32'(in_ready), 32'd1);

    // ones 0, tens 0, consumer stalls with extra beats offered
    out_ready = 1'b0;
    send(1'b0, 7'b1111110);
    send(1'b1, 7'b0000000);
    seg_sel   = 1'b0;
    seg_in    = 7'b0110000;
    seg_valid = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      chk("p2_hold_onehot", 32'(onehot_out), 32'h0001);
      chk("p2_hold_valid", 32'(out_valid), 32'd1);
      chk("p2_hold_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    idle(1);
    seg_valid = 1'b0;
    chk("p2_rel_valid", 32'(out_valid), 32'd0);
    chk("p2_rel_onehot", 32'(onehot_out), 32'd0);
    chk("p2_rel_err", 32'(err), 32'd0);
    // the beat offered during the handshake must not have been stored as ones
    send(1'b1, 7'b0110000);
    chk("p2_ignored_beat", 32'(err), 32'd1);
    chk("p2_ignored_valid", 32'(out_valid), 32'd0);
    idle(1);
    chk("p2_err_pulse", 32'(err), 32'd0);

    // invalid ones pattern, then tens first
    send(1'b0, 7'b1111111);
    chk("p3_bad_ones_err", 32'(err), 32'd1);
    chk("p3_bad_ones_ready", 32'(in_ready), 32'd1);
    idle(1);
    chk("p3_err_clear", 32'(err), 32'd0);
    send(1'b1, 7'b0110000);
    chk("p3_tens_first", 32'(err), 32'd1);
    idle(1);
    chk("p3_err_clear2", 32'(err), 32'd0);

    // timeout after 15 idle cycles in WAIT_TENS
    send(1'b0, 7'b0110000);
    idle(14);
    chk("p4_no_early_to", 32'(err), 32'd0);
    idle(1);
    chk("p4_timeout_err", 32'(err), 32'd1);
    idle(1);
    chk("p4_to_pulse", 32'(err), 32'd0);
    send(1'b1, 7'b0110000);
    chk("p4_tens_after_to", 32'(err), 32'd1);
    chk("p4_no_valid", 32'(out_valid), 32'd0);

    // beat on the timeout cycle wins: ones 1, tens 0 -> value 1
    send(1'b0, 7'b0110000);
    idle(14);
    send(1'b1, 7'b0000000);
    chk("p4b_edge_err", 32'(err), 32'd0);
    chk("p4b_edge_onehot", 32'(onehot_out), 32'h0002);
    idle(1);
    chk("p4b_release", 32'(out_valid), 32'd0);

    // restart: ones 7 replaced by ones 4, tens 1 -> value 12
    send(1'b0, 7'b1110000);
    send(1'b0, 7'b0110011);
    chk("p5_restart_err", 32'(err), 32'd0);
    send(1'b1, 7'b0110000);
    chk("p5_onehot", 32'(onehot_out), 32'h1000);
    chk("p5_valid", 32'(out_valid), 32'd1);
    idle(1);
    chk("p5_release", 32'(onehot_out), 32'd0);

    // reset mid-pair discards the stored ones digit
    send(1'b0, 7'b1011011);
    rst = 1'b1;
    #1;
    chk("p6_rst_wt_valid", 32'(out_valid), 32'd0);
    chk("p6_rst_wt_ready", 32'(in_ready), 32'd1);
    #1;
    rst = 1'b0;
    idle(1);
    send(1'b1, 7'b0110000);
    chk("p6_rst_wt_discard", 32'(err), 32'd1);

    // reset while holding clears outputs before any clock edge
    out_ready = 1'b0;
    send(1'b0, 7'b1011111);
    send(1'b1, 7'b0110000);
    chk("p6_hold_onehot", 32'(onehot_out), 32'h4000);
    #2;
    rst = 1'b1;
    #1;
    chk("p6_rst_h_valid", 32'(out_valid), 32'd0);
    chk("p6_rst_h_onehot", 32'(onehot_out), 32'd0);
    chk("p6_rst_h_ready", 32'(in_ready), 32'd1);
    #1;
    rst = 1'b0;
    idle(1);
    out_ready = 1'b1;
    send(1'b0, 7'b1011011);
    send(1'b1, 7'b0000000);
    chk("p6_after_onehot", 32'(onehot_out), 32'h0020);
    chk("p6_after_valid", 32'(out_valid), 32'd1);
    idle(1);
    chk("p6_after_release", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
